// File: rtl/viterbi_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional encoder
// and the downstream Viterbi decoder.
package viterbi_pkg;

  localparam int K      = 3;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef logic [1:0] symbol_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_e;

endpackage

// File: rtl/conv_encoder_if.sv
// Frame-in / symbol-out bundle between the byte source, the encoder and the
// Viterbi decoder's symbol input.
interface conv_encoder_if;
  import viterbi_pkg::*;

  logic [DATA_W-1:0] DataIn;
  logic              in_valid;
  logic              in_ready;
  symbol_t           Signal;
  logic              sym_valid;
  logic              frame_done;

  modport master (
    output DataIn, in_valid,
    input  in_ready, Signal, sym_valid, frame_done
  );

  modport slave (
    input  DataIn, in_valid,
    output in_ready, Signal, sym_valid, frame_done
  );

endinterface

// File: rtl/conv_enc_core.sv
// Combinational trellis step: parity symbol and next state for input bit u.
// Also used by the decoder's branch-metric logic.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic           u,
  input  logic [K-2:0]   st,
  output symbol_t        sym,
  output logic [K-2:0]   nxt
);

  logic [K-1:0] taps;

  // taps = {u, s1, s0}; s1 is the most recent bit
  assign taps = {u, st};
  assign sym  = {^(taps & G0), ^(taps & G1)};
  assign nxt  = {u, st[K-2:1]};

endmodule

// File: rtl/conv_encoder.sv
// Serialises one byte per frame MSB-first through the K=3 encoder, one 2-bit
// symbol per clock. Define CONV_ENC_TAIL_EN to append a two-bit zero flush.
//
// state | meaning
// IDLE  | ready for a frame; accept edge emits the first symbol
// DATA  | encoding the remaining payload bits
// TAIL  | flushing zeros to drive the trellis back to 00
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  conv_encoder_if.slave bus
);

  enc_state_e          state;
  logic [DATA_W-2:0]   shreg;
  logic [K-2:0]        enc_st;
  logic [CNT_W-1:0]    cnt;

  logic                core_u;
  logic [K-2:0]        core_st;
  logic [K-2:0]        core_nxt;
  symbol_t             core_sym;

  // The accept edge encodes from a cleared trellis so frames are independent.
  always_comb begin
    core_u  = 1'b0;
    core_st = enc_st;
    case (state)
      IDLE: begin
        core_u  = bus.DataIn[DATA_W-1];
        core_st = '0;
      end
      DATA:    core_u = shreg[DATA_W-2];
      default: core_u = 1'b0;
    endcase
  end

  conv_enc_core u_core (
    .u   (core_u),
    .st  (core_st),
    .sym (core_sym),
    .nxt (core_nxt)
  );

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      enc_st         <= '0;
      cnt            <= '0;
      bus.Signal     <= '0;
      bus.sym_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.frame_done <= 1'b0;
          if (bus.in_valid) begin
            bus.Signal    <= core_sym;
            bus.sym_valid <= 1'b1;
            enc_st        <= core_nxt;
            shreg         <= bus.DataIn[DATA_W-2:0];
            cnt           <= CNT_W'(1);
            state         <= DATA;
          end else begin
            bus.Signal    <= '0;
            bus.sym_valid <= 1'b0;
          end
        end
        DATA: begin
          bus.Signal    <= core_sym;
          bus.sym_valid <= 1'b1;
          enc_st        <= core_nxt;
          shreg         <= {shreg[DATA_W-3:0], 1'b0};
          cnt           <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W-1)) begin
`ifdef CONV_ENC_TAIL_EN
            cnt   <= '0;
            state <= TAIL;
`else
            bus.frame_done <= 1'b1;
            state          <= IDLE;
`endif
          end
        end
`ifdef CONV_ENC_TAIL_EN
        TAIL: begin
          bus.Signal    <= core_sym;
          bus.sym_valid <= 1'b1;
          enc_st        <= core_nxt;
          cnt           <= cnt + 1'b1;
          if (cnt == CNT_W'(K-2)) begin
            bus.frame_done <= 1'b1;
            state          <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: frame-level reference model, trellis
// inversion of the symbol stream, and literal symbol sequences.
module tb_conv_encoder;
  import viterbi_pkg::*;

`ifdef CONV_ENC_TAIL_EN
  localparam int FLEN = DATA_W + K - 1;
`else
  localparam int FLEN = DATA_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  conv_encoder_if bus ();

  conv_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  logic checking    = 1'b0;

  typedef struct {
    symbol_t sym;
    logic    done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  symbol_t    lit_q[$];
  int         busy      = 0;
  symbol_t    exp_sym   = '0;
  logic       exp_v     = 1'b0;
  logic       exp_done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Whole frame from the parity equations: p0 = u^s1^s0, p1 = u^s0.
  function automatic void gen_frame(input logic [7:0] b);
    bit   u;
    bit   s1 = 1'b0;
    bit   s0 = 1'b0;
    exp_t e;
    for (int i = 0; i < FLEN; i++) begin
      u      = (i < DATA_W) ? b[DATA_W-1-i] : 1'b0;
      e.sym  = {u ^ s1 ^ s0, u ^ s0};
      e.done = (i == FLEN - 1);
      exp_q.push_back(e);
      s0 = s1;
      s1 = u;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      byte_q.delete();
      busy     = 0;
      exp_sym  = '0;
      exp_v    = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (busy == 0 && bus.in_valid === 1'b1) begin
        gen_frame(bus.DataIn);
        byte_q.push_back(bus.DataIn);
        busy = FLEN - 1;
      end else if (busy > 0) begin
        busy--;
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e        = exp_q.pop_front();
        exp_sym  = e.sym;
        exp_v    = 1'b1;
        exp_done = e.done;
      end else begin
        exp_sym  = '0;
        exp_v    = 1'b0;
        exp_done = 1'b0;
      end
    end
  end

  // Every-cycle compare plus inversion of the symbol stream back to bytes.
  bit         dst1 = 1'b0;
  bit         dst0 = 1'b0;
  bit         du;
  int         dcnt = 0;
  logic [7:0] dbyte = '0;

  always @(negedge clk) begin
    if (rst) begin
      dcnt = 0;
      dst1 = 1'b0;
      dst0 = 1'b0;
    end
    if (checking) begin
      chk("outputs", 32'({bus.Signal, bus.sym_valid, bus.frame_done, bus.in_ready}),
          32'({exp_sym, exp_v, exp_done, (busy == 0)}));
      if (!rst && bus.sym_valid === 1'b1) begin
        du = bus.Signal[0] ^ dst0;
        chk("decode_parity", 32'(bus.Signal[1]), 32'(du ^ dst1 ^ dst0));
        if (dcnt < DATA_W) dbyte = {dbyte[6:0], du};
        dst0 = dst1;
        dst1 = du;
        dcnt++;
        if (dcnt == FLEN) begin
          dcnt = 0;
          dst0 = 1'b0;
          dst1 = 1'b0;
          if (byte_q.size() == 0) chk("decode_orphan", 32'(dbyte), 32'hffff_ffff);
          else chk("decoded_byte", 32'(dbyte), 32'(byte_q.pop_front()));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #2;
    bus.in_valid = v;
    bus.DataIn   = d;
  endtask

  // First negedge inside this task must follow the accepting edge.
  task automatic expect_stream(input string name);
    for (int k = 0; k < lit_q.size(); k++) begin
      @(negedge clk);
      chk({name, "_sym"}, 32'(bus.Signal), 32'(lit_q[k]));
      chk({name, "_valid"}, 32'(bus.sym_valid), 32'd1);
      chk({name, "_done"}, 32'(bus.frame_done), 32'((k % FLEN) == FLEN - 1));
    end
  endtask

  task automatic lit_b1();
    lit_q.push_back(2'd3); lit_q.push_back(2'd2); lit_q.push_back(2'd0); lit_q.push_back(2'd1);
    lit_q.push_back(2'd1); lit_q.push_back(2'd3); lit_q.push_back(2'd0); lit_q.push_back(2'd3);
`ifdef CONV_ENC_TAIL_EN
    lit_q.push_back(2'd2); lit_q.push_back(2'd3);
`endif
  endtask

  task automatic lit_80();
    lit_q.push_back(2'd3); lit_q.push_back(2'd2); lit_q.push_back(2'd3);
    for (int i = 3; i < FLEN; i++) lit_q.push_back(2'd0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.sym_valid), 32'd0);
    chk({name, "_done"}, 32'(bus.frame_done), 32'd0);
    chk({name, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.DataIn   = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    checking = 1'b1;

    @(negedge clk);
    chk("reset_outputs", 32'({bus.Signal, bus.sym_valid, bus.frame_done}), 32'd0);
    chk("reset_ready", 32'(bus.in_ready), 32'd1);

    // Single B1 frame
    lit_q.delete(); lit_b1();
    drive(1'b1, 8'hB1);
    drive(1'b0, 8'h00);
    expect_stream("b1");
    check_idle("b1_after");

    // 80 frame, then all-zero frame
    lit_q.delete(); lit_80();
    drive(1'b1, 8'h80);
    drive(1'b0, 8'h00);
    expect_stream("x80");
    check_idle("x80_after");

    lit_q.delete();
    for (int i = 0; i < FLEN; i++) lit_q.push_back(2'd0);
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    expect_stream("x00");

    // Back-to-back frames with in_valid held
    repeat (2) @(posedge clk);
    lit_q.delete(); lit_b1(); lit_80();
    drive(1'b1, 8'hB1);
    fork
      begin
        @(posedge clk);
        #2 bus.DataIn = 8'h80;
        repeat (FLEN) @(posedge clk);
        #2 bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        expect_stream("b2b");
      end
    join
    check_idle("b2b_after");

    // in_valid pulses and DataIn changes while busy are ignored
    lit_q.delete(); lit_b1();
    drive(1'b1, 8'hB1);
    fork
      begin
        @(posedge clk);
        #2 bus.in_valid = 1'b0; bus.DataIn = 8'h5A;
        repeat (2) @(posedge clk);
        #2 bus.in_valid = 1'b1; bus.DataIn = 8'hFF;
        repeat (3) @(posedge clk);
        #2 bus.in_valid = 1'b0; bus.DataIn = 8'h00;
      end
      begin
        @(posedge clk);
        expect_stream("busy_ign");
      end
    join
    check_idle("busy_ign_after");

    // Async reset after the 4th symbol
    drive(1'b1, 8'hB1);
    drive(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", 32'({bus.Signal, bus.sym_valid, bus.frame_done}), 32'd0);
    chk("async_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    check_idle("post_rst");
    lit_q.delete(); lit_b1();
    drive(1'b1, 8'hB1);
    drive(1'b0, 8'h00);
    expect_stream("post_rst_b1");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #2;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.DataIn   = 8'($urandom);
      rst          = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk);
    #2 rst = 1'b0; bus.in_valid = 1'b0;
    repeat (FLEN + 3) @(posedge clk);
    @(negedge clk);
    chk("drain_bytes", 32'(byte_q.size()), 32'd0);
    chk("drain_ready", 32'(bus.in_ready), 32'd1);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
